fpu_accum: RTL

//   Streaming IEEE-754 block accumulator for the DSP datapath; sits directly downstream of the sample source and

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_add.sv | 90 +++++++++
 rtl/fpu_accum.sv | 93 +++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared IEEE-754 constants and helpers for fpu_add and fpu_accum.
package fpu_pkg;

  localparam int SP_W  = 32;
  localparam int SP_EW = 8;
  localparam int SP_MW = 23;
  localparam int DP_W  = 64;
  localparam int DP_EW = 11;
  localparam int DP_MW = 52;

  localparam logic [63:0] POS_ZERO    = 64'h0;
  localparam logic [63:0] SP_EXP_MASK = 64'h0000_0000_7f80_0000;
  localparam logic [63:0] DP_EXP_MASK = 64'h7ff0_0000_0000_0000;

  // Accumulator control states.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } acc_state_e;

  // True when the exponent field is all ones (Inf or NaN); x is zero-extended for single.
  function automatic logic is_inf_nan(input logic [63:0] x, input logic dbl);
    if (dbl) return (x & DP_EXP_MASK) == DP_EXP_MASK;
    else     return (x & SP_EXP_MASK) == SP_EXP_MASK;
  endfunction

endpackage

// File: rtl/fpu_add.sv
// Combinational IEEE-754 adder, round-to-nearest-even, subnormals handled.
module fpu_add import fpu_pkg::*; #(
  parameter int double = 0,
  localparam int W  = (double != 0) ? DP_W  : SP_W,
  localparam int EW = (double != 0) ? DP_EW : SP_EW,
  localparam int MW = (double != 0) ? DP_MW : SP_MW
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  // hidden bit + mantissa + guard/round/sticky
  localparam int FW = MW + 4;
  localparam logic [EW-1:0] EMAX  = '1;
  localparam logic [EW+1:0] ONE   = (EW+2)'(1);
  localparam logic [EW+1:0] D_MAX = (EW+2)'(FW);

  logic [W-1:0]  big, sml;
  logic [EW+1:0] e_big, e_sml, e_r, d;
  logic [FW-1:0] m_big, m_sml, m_sh, m_n;
  logic [FW:0]   sum;
  logic [MW+1:0] m_rnd;
  logic          sticky, up, a_nan, b_nan, a_inf, b_inf;

  // Align the smaller operand, add/subtract, normalise, round, then patch specials.
  always_comb begin
    a_nan = (a_i[W-2:MW] == EMAX) && (a_i[MW-1:0] != '0);
    b_nan = (b_i[W-2:MW] == EMAX) && (b_i[MW-1:0] != '0);
    a_inf = (a_i[W-2:MW] == EMAX) && (a_i[MW-1:0] == '0);
    b_inf = (b_i[W-2:MW] == EMAX) && (b_i[MW-1:0] == '0);
    if (a_i[W-2:0] >= b_i[W-2:0]) begin
      big = a_i;
      sml = b_i;
    end else begin
      big = b_i;
      sml = a_i;
    end
    // subnormals share the minimum exponent but have no hidden bit
    e_big = (big[W-2:MW] == '0) ? ONE : {2'b00, big[W-2:MW]};
    e_sml = (sml[W-2:MW] == '0) ? ONE : {2'b00, sml[W-2:MW]};
    m_big = {big[W-2:MW] != '0, big[MW-1:0], 3'b000};
    m_sml = {sml[W-2:MW] != '0, sml[MW-1:0], 3'b000};
    d     = e_big - e_sml;
    if (d >= D_MAX) begin
      m_sh   = '0;
      sticky = (m_sml != '0);
    end else begin
      m_sh   = m_sml >> d;
      sticky = (m_sml & ~({FW{1'b1}} << d)) != '0;
    end
    m_sh[0] = m_sh[0] | sticky;
    if (big[W-1] == sml[W-1]) sum = {1'b0, m_big} + {1'b0, m_sh};
    else                      sum = {1'b0, m_big} - {1'b0, m_sh};
    e_r = e_big;
    if (sum[FW]) begin
      m_n    = sum[FW:1];
      m_n[0] = m_n[0] | sum[0];
      e_r    = e_r + ONE;
    end else begin
      m_n = sum[FW-1:0];
    end
    // left-normalise after cancellation, stopping at the subnormal exponent
    for (int i = 0; i < FW; i++) begin
      if (!m_n[FW-1] && (e_r > ONE)) begin
        m_n = m_n << 1;
        e_r = e_r - ONE;
      end
    end
    up    = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    m_rnd = {1'b0, m_n[FW-1:3]} + (MW+2)'(up);
    if (m_rnd[MW+1]) begin
      m_rnd = m_rnd >> 1;
      e_r   = e_r + ONE;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[W-1] != b_i[W-1])))
      y_o = {1'b0, EMAX, 1'b1, (MW-1)'(0)};
    else if (a_inf)
      y_o = a_i;
    else if (b_inf)
      y_o = b_i;
    else if (sum == '0)
      y_o = {a_i[W-1] & b_i[W-1], (W-1)'(0)};
    else if (e_r >= {2'b00, EMAX})
      y_o = {big[W-1], EMAX, MW'(0)};
    else
      y_o = {big[W-1], m_rnd[MW] ? e_r[EW-1:0] : EW'(0), m_rnd[MW-1:0]};
  end

endmodule

// File: rtl/fpu_accum.sv
// Streaming block accumulator: sums LEN samples through one fpu_add.
// Optional early block end via flush when FPU_ACC_FLUSH_EN is defined.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its data stay stable until that edge; ready may depend on state only.
module fpu_accum import fpu_pkg::*; #(
  parameter int DOUBLE = 0,
  parameter int LEN    = 16,
  localparam int W  = (DOUBLE != 0) ? DP_W : SP_W,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_exc,
  output logic          out_valid,
  input  logic          out_ready
);

  acc_state_e    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exc_q, exc_d;

`ifndef FPU_ACC_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  fpu_add #(.double(DOUBLE)) u_add (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (sum)
  );

  // Next-state: accumulate in ACC, hold the result in DONE until taken.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    exc_d    = exc_q;
    in_ready = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          exc_d = exc_q | is_inf_nan(64'(sum), DOUBLE != 0);
          if (cnt_q == CW'(LEN - 1)) state_d = ST_DONE;
        end
`ifdef FPU_ACC_FLUSH_EN
        // a sample accepted alongside flush is already folded into cnt_d
        if (flush && (cnt_d != '0)) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = POS_ZERO[W-1:0];
          cnt_d   = '0;
          exc_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State, running sum, count and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= POS_ZERO[W-1:0];
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : '0;
  assign out_exc   = out_valid & exc_q;

endmodule
